sw_debounce: RTL and testbench

Per-bit slide-switch conditioner for the DE2 board. It sits directly upstream of the half adder and the other switch-driven datapath blocks. Each raw `SW_IN` bit passes through a two-flop synchronizer and a stability-counter state machine. The block emits a clean, glitch-free level on `SW_OUT`, plus one-cycle rise and fall strobes. `SW_OUT[1:0]` feeds the adder's `a`/`b` operands.

---
 rtl/sw_debounce.sv | 106 ++++++++++
 tb/tb_sw_debounce.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// sw_debounce: per-bit slide-switch conditioner (2-flop sync + stability counter FSM).
// Latency: STABLE_CYCLES+2 cycles from a stable SW_IN change to SW_OUT and its strobe.
// Backpressure: none; free-running, every channel is evaluated every cycle.
//
// Ports:
//   CLOCK_50  system clock, rising edge
//   RST       synchronous active-high reset, priority over all updates
//   SW_IN     raw asynchronous switch levels (WIDTH bits)
//   SW_OUT    debounced levels (registered)
//   SW_RISE   one-cycle strobe when SW_OUT[i] goes 0->1 (registered)
//   SW_FALL   one-cycle strobe when SW_OUT[i] goes 1->0 (registered)
module sw_debounce #(
    parameter int WIDTH         = 2,
    parameter int STABLE_CYCLES = 1000000
) (
    input  logic             CLOCK_50,
    input  logic             RST,
    input  logic [WIDTH-1:0] SW_IN,
    output logic [WIDTH-1:0] SW_OUT,
    output logic [WIDTH-1:0] SW_RISE,
    output logic [WIDTH-1:0] SW_FALL
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    // The counter clears when it reaches this value, so it never wraps.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        logic             s1_q, s1_d;
        logic             s2_q, s2_d;
        logic             out_q, out_d;
        logic             rise_q, rise_d;
        logic             fall_q, fall_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        state_t           state_q, state_d;

        always_comb begin
            s1_d    = SW_IN[i];
            s2_d    = s1_q;
            out_d   = out_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            cnt_d   = cnt_q;
            state_d = state_q;
            unique case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    // The first disagreeing cycle already counts toward the window.
                    if (s2_q != out_q) begin
                        state_d = ST_COUNT;
                        cnt_d   = CNT_W'(1);
                    end
                end
                ST_COUNT: begin
                    if (s2_q == out_q) begin
                        // Bounced back: discard the partial window.
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        out_d   = s2_q;
                        rise_d  = s2_q;
                        fall_d  = ~s2_q;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        always_ff @(posedge CLOCK_50) begin
            if (RST) begin
                s1_q    <= 1'b0;
                s2_q    <= 1'b0;
                out_q   <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
                cnt_q   <= '0;
                state_q <= ST_IDLE;
            end else begin
                s1_q    <= s1_d;
                s2_q    <= s2_d;
                out_q   <= out_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
                cnt_q   <= cnt_d;
                state_q <= state_d;
            end
        end

        assign SW_OUT[i]  = out_q;
        assign SW_RISE[i] = rise_q;
        assign SW_FALL[i] = fall_q;
    end : g_chan

endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: directed scenarios with literal expectations plus a randomized run,
// all checked every cycle against a window-based behavioural model of the debouncer.
module tb_sw_debounce;

    localparam int W    = 2;
    localparam int SC   = 4;
    localparam int MAXE = 8192;

    logic         CLOCK_50;
    logic         RST;
    logic [W-1:0] SW_IN;
    logic [W-1:0] SW_OUT;
    logic [W-1:0] SW_RISE;
    logic [W-1:0] SW_FALL;

    int n_cmp = 0;
    int n_bad = 0;

    sw_debounce #(.WIDTH(W), .STABLE_CYCLES(SC)) dut (
        .CLOCK_50 (CLOCK_50),
        .RST      (RST),
        .SW_IN    (SW_IN),
        .SW_OUT   (SW_OUT),
        .SW_RISE  (SW_RISE),
        .SW_FALL  (SW_FALL)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // syn_h[n] is the synchronized level the design acts on at edge n.
    // A channel flips at edge n when the last SC synchronized samples all differ
    // from the current output and none of them precede the last flip or reset.
    logic [W-1:0] s1_h  [MAXE];
    logic [W-1:0] s2_h  [MAXE];
    logic [W-1:0] syn_h [MAXE];
    logic [W-1:0] m_out, m_rise, m_fall;
    int           last_evt [W];
    int           e = 0;

    initial begin
        s1_h[0] = '0;
        s2_h[0] = '0;
        m_out   = '0;
        m_rise  = '0;
        m_fall  = '0;
        for (int i = 0; i < W; i++) last_evt[i] = 0;
    end

    always @(posedge CLOCK_50) begin
        if (e < MAXE - 1) begin
            e++;
            m_rise = '0;
            m_fall = '0;
            if (RST) begin
                s1_h[e] = '0;
                s2_h[e] = '0;
                m_out   = '0;
                for (int i = 0; i < W; i++) last_evt[i] = e;
            end else begin
                s1_h[e]  = SW_IN;
                s2_h[e]  = s1_h[e-1];
                syn_h[e] = s2_h[e-1];
                for (int i = 0; i < W; i++) begin
                    bit all_diff;
                    all_diff = (e - last_evt[i]) >= SC;
                    if (all_diff)
                        for (int j = e - SC + 1; j <= e; j++)
                            if (syn_h[j][i] == m_out[i]) all_diff = 0;
                    if (all_diff) begin
                        m_out[i]    = ~m_out[i];
                        m_rise[i]   = m_out[i];
                        m_fall[i]   = ~m_out[i];
                        last_evt[i] = e;
                    end
                end
            end
            #1;
            chk("model_out",  SW_OUT,  m_out);
            chk("model_rise", SW_RISE, m_rise);
            chk("model_fall", SW_FALL, m_fall);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Drive a new level, then expect the change exactly on the 6th edge.
    task automatic step_check(input logic [W-1:0] sw, input logic [W-1:0] old_out,
                              input logic [W-1:0] new_out, input logic [W-1:0] rise,
                              input logic [W-1:0] fall);
        SW_IN = sw;
        for (int t = 1; t <= 5; t++) begin
            tick();
            chk("step_hold_out",  SW_OUT,  old_out);
            chk("step_hold_rise", SW_RISE, 2'b00);
            chk("step_hold_fall", SW_FALL, 2'b00);
        end
        tick();
        chk("step_out",  SW_OUT,  new_out);
        chk("step_rise", SW_RISE, rise);
        chk("step_fall", SW_FALL, fall);
        tick();
        chk("step_after_out",  SW_OUT,  new_out);
        chk("step_after_rise", SW_RISE, 2'b00);
        chk("step_after_fall", SW_FALL, 2'b00);
        tick();
        tick();
    endtask

    initial begin
        int hold;
        RST   = 1'b1;
        SW_IN = 2'b11;

        // Reset values, then a held-high input debounces normally.
        for (int t = 0; t < 3; t++) begin
            tick();
            chk("rst_out",  SW_OUT,  2'b00);
            chk("rst_rise", SW_RISE, 2'b00);
            chk("rst_fall", SW_FALL, 2'b00);
        end
        RST = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            tick();
            chk("post_rst_hold", SW_OUT, 2'b00);
        end
        tick();
        chk("post_rst_out",  SW_OUT,  2'b11);
        chk("post_rst_rise", SW_RISE, 2'b11);
        tick();
        chk("post_rst_rise_clr", SW_RISE, 2'b00);
        tick();

        // Clean steps on bit 0 only; bit 1 must not move.
        step_check(2'b10, 2'b11, 2'b10, 2'b00, 2'b01);
        step_check(2'b11, 2'b10, 2'b11, 2'b01, 2'b00);

        // Bounce on bit 0 before settling high.
        step_check(2'b10, 2'b11, 2'b10, 2'b00, 2'b01);
        SW_IN = 2'b11; tick(); chk("bounce_rise", SW_RISE, 2'b00);
        SW_IN = 2'b10; tick(); chk("bounce_rise", SW_RISE, 2'b00);
        SW_IN = 2'b11; tick(); chk("bounce_rise", SW_RISE, 2'b00);
        SW_IN = 2'b10; tick(); chk("bounce_rise", SW_RISE, 2'b00);
        step_check(2'b11, 2'b10, 2'b11, 2'b01, 2'b00);

        // Glitch of 3 cycles on bit 1: rejected.
        SW_IN = 2'b01;
        for (int t = 1; t <= 12; t++) begin
            if (t == 4) SW_IN = 2'b11;
            tick();
            chk("glitch3_out",  SW_OUT,  2'b11);
            chk("glitch3_fall", SW_FALL, 2'b00);
        end

        // Excursion of exactly 4 cycles: accepted, then recovers.
        SW_IN = 2'b01;
        for (int t = 1; t <= 12; t++) begin
            if (t == 5) SW_IN = 2'b11;
            tick();
            chk("glitch4_out",  SW_OUT,  (t >= 6 && t < 10) ? 2'b01 : 2'b11);
            chk("glitch4_fall", SW_FALL, (t == 6) ? 2'b10 : 2'b00);
            chk("glitch4_rise", SW_RISE, (t == 10) ? 2'b10 : 2'b00);
        end

        // Both channels change on the same edge.
        step_check(2'b01, 2'b11, 2'b01, 2'b00, 2'b10);
        step_check(2'b10, 2'b01, 2'b10, 2'b10, 2'b01);

        // Reset in the middle of a count discards it.
        SW_IN = 2'b11;
        for (int t = 1; t <= 4; t++) begin
            tick();
            chk("midrst_pre_out",  SW_OUT,  2'b10);
            chk("midrst_pre_rise", SW_RISE, 2'b00);
        end
        RST = 1'b1;
        tick();
        chk("midrst_out",  SW_OUT,  2'b00);
        chk("midrst_rise", SW_RISE, 2'b00);
        RST = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            tick();
            chk("midrst_hold", SW_OUT, 2'b00);
        end
        tick();
        chk("midrst_rise_out", SW_OUT,  2'b11);
        chk("midrst_rise_stb", SW_RISE, 2'b11);
        tick();

        // Randomized run: hold lengths straddle the acceptance window, rare resets.
        hold = 0;
        for (int c = 0; c < 2500; c++) begin
            if (hold == 0) begin
                SW_IN = W'($urandom);
                hold  = $urandom_range(1, 8);
            end
            hold--;
            RST = ($urandom_range(0, 299) == 0);
            tick();
        end
        RST = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
